// File: rtl/pipe_pkg.sv
// Shared widths, control-bus bit positions and slice-level types for the
// configurable inter-stage register chain.
package pipe_pkg;

    localparam int DEF_DATA_W   = 192;
    localparam int DEF_CTRL_W   = 12;
    localparam int DEF_REGNUM_W = 5;
    localparam int DEF_CNT_W    = 32;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_ALUSRC   = 5;

    typedef struct packed {
        logic                    valid;
        logic [DEF_DATA_W-1:0]   data;
        logic [DEF_CTRL_W-1:0]   ctrl;
        logic [DEF_REGNUM_W-1:0] wbreg;
    } slice_rec_t;

    typedef enum logic [1:0] {
        SLICE_HOLD   = 2'd0,
        SLICE_LOAD   = 2'd1,
        SLICE_BUBBLE = 2'd2
    } slice_op_e;

    typedef enum logic [2:0] {
        OP_STALL          = 3'd0,
        OP_STALL_BUBBLE   = 3'd1,
        OP_ADVANCE        = 3'd2,
        OP_ADVANCE_BUBBLE = 3'd3,
        OP_FLUSH          = 3'd4
    } chain_op_e;

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Handshake, payload, hazard-query and counter signals of pipe_stage_chain.
interface pipe_stage_chain_if #(
    parameter int DATA_W   = 192,
    parameter int CTRL_W   = 12,
    parameter int REGNUM_W = 5,
    parameter int DEPTH    = 1,
    parameter int CNT_W    = 32
);
    logic                EN;
    logic                bb;
    logic                flush;
    logic                valid_in;
    logic [DATA_W-1:0]   data_in;
    logic [CTRL_W-1:0]   ctrl_in;
    logic [REGNUM_W-1:0] wbreg_in;
    logic                valid_out;
    logic [DATA_W-1:0]   data_out;
    logic [CTRL_W-1:0]   ctrl_out;
    logic [REGNUM_W-1:0] wbreg_out;
    logic [DEPTH-1:0]    stage_valid;
    logic [REGNUM_W-1:0] q_reg;
    logic [DEPTH-1:0]    q_hit;
    logic                q_hit_any;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    bubble_cnt;
    logic [CNT_W-1:0]    flush_cnt;

    modport master (
        output EN, bb, flush, valid_in, data_in, ctrl_in, wbreg_in, q_reg,
        input  valid_out, data_out, ctrl_out, wbreg_out, stage_valid,
               q_hit, q_hit_any, stall_cnt, bubble_cnt, flush_cnt
    );

    modport slave (
        input  EN, bb, flush, valid_in, data_in, ctrl_in, wbreg_in, q_reg,
        output valid_out, data_out, ctrl_out, wbreg_out, stage_valid,
               q_hit, q_hit_any, stall_cnt, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_slice.sv
// One register slice of the chain: load a record, turn into a bubble in
// place, or hold; rst clears everything.
module pipe_slice
    import pipe_pkg::*;
#(
    parameter int DATA_W              = DEF_DATA_W,
    parameter int CTRL_W              = DEF_CTRL_W,
    parameter int REGNUM_W            = DEF_REGNUM_W,
    parameter int ZERO_DATA_ON_BUBBLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  slice_op_e           op,
    input  logic                load_valid,
    input  logic [DATA_W-1:0]   load_data,
    input  logic [CTRL_W-1:0]   load_ctrl,
    input  logic [REGNUM_W-1:0] load_wbreg,
    output logic                valid,
    output logic [DATA_W-1:0]   data,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [REGNUM_W-1:0] wbreg
);

    logic                valid_d, valid_q;
    logic [DATA_W-1:0]   data_d,  data_q;
    logic [CTRL_W-1:0]   ctrl_d,  ctrl_q;
    logic [REGNUM_W-1:0] wbreg_d, wbreg_q;

    // An invalid record never carries control or a writeback target, so
    // downstream hazard logic can trust ctrl/wbreg without re-gating.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        wbreg_d = wbreg_q;
        case (op)
            SLICE_LOAD: begin
                valid_d = load_valid;
                data_d  = load_data;
                ctrl_d  = load_valid ? load_ctrl  : '0;
                wbreg_d = load_valid ? load_wbreg : '0;
            end
            SLICE_BUBBLE: begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                wbreg_d = '0;
                if (ZERO_DATA_ON_BUBBLE != 0) begin
                    data_d = '0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
            wbreg_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            wbreg_q <= wbreg_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign ctrl  = ctrl_q;
    assign wbreg = wbreg_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-deep pipeline register chain with stall, bubble and flush control,
// per-slice hazard query and saturating event counters.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int DATA_W              = DEF_DATA_W,
    parameter int CTRL_W              = DEF_CTRL_W,
    parameter int REGNUM_W            = DEF_REGNUM_W,
    parameter int DEPTH               = 1,
    parameter int REGWRITE_BIT        = CTRL_REGWRITE,
    parameter int ZERO_DATA_ON_BUBBLE = 1,
    parameter int CNT_W               = DEF_CNT_W
) (
    input logic              clk,
    input logic              CLR,
    pipe_stage_chain_if.slave bus
);

    if (DEPTH < 1) begin : g_depth_check
        $error("pipe_stage_chain: DEPTH must be at least 1");
    end

    chain_op_e           chain_op;
    slice_op_e           slice_op    [DEPTH];
    logic                src_valid   [DEPTH];
    logic [DATA_W-1:0]   src_data    [DEPTH];
    logic [CTRL_W-1:0]   src_ctrl    [DEPTH];
    logic [REGNUM_W-1:0] src_wbreg   [DEPTH];
    logic                slice_valid [DEPTH];
    logic [DATA_W-1:0]   slice_data  [DEPTH];
    logic [CTRL_W-1:0]   slice_ctrl  [DEPTH];
    logic [REGNUM_W-1:0] slice_wbreg [DEPTH];
    logic [DEPTH-1:0]    stage_valid;
    logic [DEPTH-1:0]    hit;
    logic [CNT_W-1:0]    stall_cnt_d,  stall_cnt_q;
    logic [CNT_W-1:0]    bubble_cnt_d, bubble_cnt_q;
    logic [CNT_W-1:0]    flush_cnt_d,  flush_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Priority below CLR: flush, advance+bubble, advance, stall+bubble, stall.
    always_comb begin
        chain_op = OP_STALL;
        if (bus.flush) begin
            chain_op = OP_FLUSH;
        end else if (bus.EN && bus.bb) begin
            chain_op = OP_ADVANCE_BUBBLE;
        end else if (bus.EN) begin
            chain_op = OP_ADVANCE;
        end else if (bus.bb) begin
            chain_op = OP_STALL_BUBBLE;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slice_op[i] = SLICE_HOLD;
            case (chain_op)
                OP_FLUSH:          slice_op[i] = SLICE_BUBBLE;
                OP_ADVANCE:        slice_op[i] = SLICE_LOAD;
                OP_ADVANCE_BUBBLE: slice_op[i] = (i == 0) ? SLICE_BUBBLE : SLICE_LOAD;
                OP_STALL_BUBBLE:   slice_op[i] = (i == 0) ? SLICE_BUBBLE : SLICE_HOLD;
                default:           slice_op[i] = SLICE_HOLD;
            endcase
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slice
        if (i == 0) begin : g_head
            assign src_valid[i] = bus.valid_in;
            assign src_data[i]  = bus.data_in;
            assign src_ctrl[i]  = bus.ctrl_in;
            assign src_wbreg[i] = bus.wbreg_in;
        end else begin : g_body
            assign src_valid[i] = slice_valid[i-1];
            assign src_data[i]  = slice_data[i-1];
            assign src_ctrl[i]  = slice_ctrl[i-1];
            assign src_wbreg[i] = slice_wbreg[i-1];
        end

        pipe_slice #(
            .DATA_W              (DATA_W),
            .CTRL_W              (CTRL_W),
            .REGNUM_W            (REGNUM_W),
            .ZERO_DATA_ON_BUBBLE (ZERO_DATA_ON_BUBBLE)
        ) u_slice (
            .clk        (clk),
            .rst        (CLR),
            .op         (slice_op[i]),
            .load_valid (src_valid[i]),
            .load_data  (src_data[i]),
            .load_ctrl  (src_ctrl[i]),
            .load_wbreg (src_wbreg[i]),
            .valid      (slice_valid[i]),
            .data       (slice_data[i]),
            .ctrl       (slice_ctrl[i]),
            .wbreg      (slice_wbreg[i])
        );
    end

    // Register 0 is hard-wired zero, so it never produces a hazard.
    always_comb begin
        stage_valid = '0;
        hit         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            stage_valid[i] = slice_valid[i];
            hit[i] = slice_valid[i] && slice_ctrl[i][REGWRITE_BIT]
                     && (slice_wbreg[i] == bus.q_reg) && (bus.q_reg != '0);
        end
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (chain_op == OP_STALL || chain_op == OP_STALL_BUBBLE) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (chain_op == OP_ADVANCE_BUBBLE || chain_op == OP_STALL_BUBBLE) begin
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end
        if (chain_op == OP_FLUSH) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bus.valid_out   = slice_valid[DEPTH-1];
    assign bus.data_out    = slice_data[DEPTH-1];
    assign bus.ctrl_out    = slice_ctrl[DEPTH-1];
    assign bus.wbreg_out   = slice_wbreg[DEPTH-1];
    assign bus.stage_valid = stage_valid;
    assign bus.q_hit       = hit;
    assign bus.q_hit_any   = |hit;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.bubble_cnt  = bubble_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised successor to the fixed inter-stage registers (EX/MEM register and signal pair), merged into one block.
- Carries a payload bus, a control bus and a writeback register number through DEPTH register slices.
- Provides per-slice valid tracking, stall, bubble and flush, hazard-query match outputs, and saturating stall/bubble/flush counters.
- Instanced between any two pipeline stages; DEPTH>1 serves multi-cycle MEM/EX paths.

Parameters:
- DATA_W, 192: payload width (IR, PC, R1, R2, RD1, RD2 = 6x32).
- CTRL_W, 12: control-signal bundle width.
- REGNUM_W, 5: writeback register number width.
- DEPTH, 1: number of register slices (>=1; 0 is illegal, elaboration error).
- REGWRITE_BIT, 0: index of RegWrite within the control bus.
- ZERO_DATA_ON_BUBBLE, 1: 1 = bubble/flush also zeros payload; 0 = payload held, only valid/ctrl/wbreg zeroed.
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- CLR  in  1  synchronous active-high reset.
- EN  in  1  advance enable; 0 = stall.
- bb  in  1  bubble request at slice 0.
- flush  in  1  kill all in-flight slices.
- valid_in  in  1  incoming instruction valid.
- data_in  in  DATA_W  incoming payload.
- ctrl_in  in  CTRL_W  incoming control bundle.
- wbreg_in  in  REGNUM_W  incoming writeback register number.
- valid_out  out  1  last-slice valid.
- data_out  out  DATA_W  last-slice payload.
- ctrl_out  out  CTRL_W  last-slice control.
- wbreg_out  out  REGNUM_W  last-slice writeback register number.
- stage_valid  out  DEPTH  per-slice valid; bit 0 = youngest.
- q_reg  in  REGNUM_W  hazard query register number.
- q_hit  out  DEPTH  per-slice match.
- q_hit_any  out  1  OR of q_hit.
- stall_cnt  out  CNT_W  cycles with EN=0 (excluding CLR/flush cycles).
- bubble_cnt  out  CNT_W  bubbles inserted.
- flush_cnt  out  CNT_W  flush events.

Behaviour:
- Reset: CLR=1 zeros every slice (valid, data, ctrl, wbreg) and all counters. All outputs read 0 the cycle after.
- Per-cycle priority, highest first: CLR > flush > (EN&bb) > EN > (!EN&bb) > hold.
- flush:
  - every slice gets valid=0, ctrl=0, wbreg=0.
  - payload is zeroed if ZERO_DATA_ON_BUBBLE=1, else held.
  - flush_cnt+1.
  - EN and bb are ignored that cycle.
- EN&bb: chain shifts (slice i <= slice i-1); slice 0 loads a bubble (same zeroing rule as flush); bubble_cnt+1.
- EN only: chain shifts; slice 0 <= {valid_in, data_in, ctrl_in, wbreg_in}.
  - valid_in=0 loads ctrl=0 and wbreg=0, with payload stored as given.
- !EN&bb: slices 1..DEPTH-1 hold; slice 0 becomes a bubble in place; bubble_cnt+1; stall_cnt+1.
- !EN only: all slices hold; stall_cnt+1.
- Latency: with EN held high, an input appears on the outputs exactly DEPTH cycles after capture. The outputs are registered last-slice state with no combinational bypass.
- q_hit[i] (combinational) = stage_valid[i] & ctrl[i][REGWRITE_BIT] & (wbreg[i]==q_reg) & (q_reg!=0). Register 0 never hits.
- Counters saturate at all-ones and never wrap.
- CLR mid-stall or mid-flush wins outright; counters restart from 0.
- DEPTH=1 is cycle-equivalent to the legacy EX/MEM register pair under EN/CLR/bb, with ZERO_DATA_ON_BUBBLE=1.

Decomposition:
- pipe_pkg holds:
  - default width constants (DATA_W, CTRL_W, REGNUM_W);
  - control-bit index constants (REGWRITE_BIT, MEMTOREG_BIT, MEMWRITE_BIT, ...);
  - a slice-record typedef {valid, data, ctrl, wbreg}.
- Sub-module pipe_slice: one slice with load/bubble/hold/clear controls. It is generated DEPTH times; the counters and query logic stay in the top.

Test Plan:
- DEPTH=3, EN=1, inject valid_in=1 data_in=0xA5.. at cycle 0 -> valid_out=1, data_out=0xA5.. at cycle 3 exactly; stage_valid = 001, 010, 100 on successive cycles.
- DEPTH=2, EN=0 for 4 cycles with a valid instruction in slice 1 -> outputs unchanged 4 cycles, stall_cnt=4; then EN=1 resumes.
- DEPTH=2, EN=0 with bb=1 for 1 cycle -> stage_valid[0]=0 and ctrl cleared, slice 1 unchanged, bubble_cnt=1, stall_cnt=1.
- flush with slices full, ZERO_DATA_ON_BUBBLE=0 -> valid/ctrl/wbreg=0 next cycle, data_out unchanged, flush_cnt=1; same with EN=1,bb=1 asserted -> flush wins.
- Slice 1 holds RegWrite=1 with wbreg=8: q_reg=8 -> q_hit=10, q_hit_any=1; q_reg=0 with wbreg=0 -> no hit; RegWrite=0 -> no hit.
- CNT_W=4: stall 20 cycles -> stall_cnt=15 (saturated); CLR=1 -> all outputs and counters 0 next cycle.
